// File: rtl/multicycle_ctrl.sv
// ============================================================================
//  multicycle_ctrl : FETCH/DECODE/EXEC/MEM/WB sequencer for a multi-cycle
//                    RV32I datapath sharing one memory port.
//  Revision 1.0
// ============================================================================
`default_nettype none

module multicycle_ctrl #(
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [6:0]       opcode_i,
  input  logic             alu_zero_i,
  input  logic             mem_ready_i,
  output logic             mem_req_o,
  output logic             mem_we_o,
  output logic             addr_sel_o,
  output logic             ir_we_o,
  output logic             pc_we_o,
  output logic             pc_src_o,
  output logic             alu_src_o,
  output logic [1:0]       alu_op_o,
  output logic             reg_we_o,
  output logic             mem_to_reg_o,
  output logic             retire_o,
  output logic [CNT_W-1:0] retired_cnt_o,
  output logic             trap_o,
  output logic             bus_err_o
);

  localparam int TMO_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_TRAP   = 3'd7
  } state_e;

  typedef enum logic [2:0] {
    C_R, C_I, C_LOAD, C_STORE, C_BRANCH, C_ILL
  } cls_e;

  state_e           state_q, state_d;
  cls_e             cls_q, cls_d, cls_dec;
  logic [TMO_W-1:0] tmo_q, tmo_d;
  logic [CNT_W-1:0] cnt_q;
  logic             trap_q, bus_err_q;

  logic       mem_req, mem_we, addr_sel, ir_we, pc_we, pc_src, alu_src;
  logic [1:0] alu_op;
  logic       reg_we, mem_to_reg, retire, tmo_wait, tmo_hit;

  always_comb begin
    unique case (opcode_i)
      7'b0110011: cls_dec = C_R;
      7'b0010011: cls_dec = C_I;
      7'b0000011: cls_dec = C_LOAD;
      7'b0100011: cls_dec = C_STORE;
      7'b1100011: cls_dec = C_BRANCH;
      default:    cls_dec = C_ILL;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    cls_d      = cls_q;
    mem_req    = 1'b0;
    mem_we     = 1'b0;
    addr_sel   = 1'b0;
    ir_we      = 1'b0;
    pc_we      = 1'b0;
    pc_src     = 1'b0;
    alu_src    = 1'b0;
    alu_op     = 2'b00;
    reg_we     = 1'b0;
    mem_to_reg = 1'b0;
    retire     = 1'b0;
    tmo_wait   = 1'b0;
    tmo_hit    = 1'b0;

    unique case (state_q)
      S_FETCH: begin
        mem_req = 1'b1;
        if (mem_ready_i) begin
          ir_we   = 1'b1;
          pc_we   = 1'b1;
          state_d = S_DECODE;
        end else begin
          tmo_wait = 1'b1;
        end
      end
      S_DECODE: begin
        cls_d   = cls_dec;
        state_d = (cls_dec == C_ILL) ? S_TRAP : S_EXEC;
      end
      S_EXEC: begin
        unique case (cls_q)
          C_R: begin
            alu_op  = 2'b10;
            state_d = S_WB;
          end
          C_I: begin
            alu_src = 1'b1;
            alu_op  = 2'b10;
            state_d = S_WB;
          end
          C_LOAD, C_STORE: begin
            alu_src = 1'b1;
            state_d = S_MEM;
          end
          C_BRANCH: begin
            alu_op  = 2'b01;
            pc_we   = alu_zero_i;
            pc_src  = alu_zero_i;
            retire  = 1'b1;
            state_d = S_FETCH;
          end
          default: state_d = S_TRAP;
        endcase
      end
      S_MEM: begin
        mem_req  = 1'b1;
        addr_sel = 1'b1;
        mem_we   = (cls_q == C_STORE);
        alu_src  = 1'b1;
        if (mem_ready_i) begin
          if (cls_q == C_STORE) begin
            retire  = 1'b1;
            state_d = S_FETCH;
          end else begin
            state_d = S_WB;
          end
        end else begin
          tmo_wait = 1'b1;
        end
      end
      S_WB: begin
        reg_we     = 1'b1;
        mem_to_reg = (cls_q == C_LOAD);
        retire     = 1'b1;
        state_d    = S_FETCH;
      end
      default: state_d = S_TRAP;
    endcase

    // A ready on the final allowed cycle is not a wait cycle, so it never traps.
    if (TIMEOUT != 0 && tmo_wait && tmo_q == TMO_W'(TIMEOUT - 1)) begin
      tmo_hit = 1'b1;
      state_d = S_TRAP;
    end

    if (state_d != state_q) tmo_d = '0;
    else if (tmo_wait)      tmo_d = tmo_q + TMO_W'(1);
    else                    tmo_d = tmo_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_FETCH;
      cls_q     <= C_R;
      tmo_q     <= '0;
      cnt_q     <= '0;
      trap_q    <= 1'b0;
      bus_err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cls_q   <= cls_d;
      tmo_q   <= tmo_d;
      if (retire)            cnt_q     <= cnt_q + CNT_W'(1);
      if (state_d == S_TRAP) trap_q    <= 1'b1;
      if (tmo_hit)           bus_err_q <= 1'b1;
    end
  end

  // Registers only clear at the edge, so outputs are forced low while rst is high.
  assign mem_req_o     = mem_req    & ~rst;
  assign mem_we_o      = mem_we     & ~rst;
  assign addr_sel_o    = addr_sel   & ~rst;
  assign ir_we_o       = ir_we      & ~rst;
  assign pc_we_o       = pc_we      & ~rst;
  assign pc_src_o      = pc_src     & ~rst;
  assign alu_src_o     = alu_src    & ~rst;
  assign alu_op_o      = alu_op     & {2{~rst}};
  assign reg_we_o      = reg_we     & ~rst;
  assign mem_to_reg_o  = mem_to_reg & ~rst;
  assign retire_o      = retire     & ~rst;
  assign retired_cnt_o = rst ? '0 : cnt_q;
  assign trap_o        = trap_q     & ~rst;
  assign bus_err_o     = bus_err_q  & ~rst;

endmodule

`default_nettype wire

// File: tb/tb_multicycle_ctrl.sv
// ============================================================================
//  tb_multicycle_ctrl : random instruction stream against a latency/enable
//                       reference model, plus reset, trap and timeout cases.
//  Revision 1.0
// ============================================================================
`default_nettype none

module tb_multicycle_ctrl;

  localparam int TIMEOUT = 4;
  localparam int CNT_W   = 4;
  localparam int BRANCH = 4, R = 0, I = 1, LOAD = 2, STORE = 3;

  logic clk = 1'b0, rst = 1'b1;
  logic [6:0] opcode = 7'd0;
  logic alu_zero = 1'b0, mem_ready = 1'b0;
  logic mem_req, mem_we, addr_sel, ir_we, pc_we, pc_src, alu_src;
  logic [1:0] alu_op;
  logic reg_we, mem_to_reg, retire, trap, bus_err;
  logic [CNT_W-1:0] retired_cnt;

  multicycle_ctrl #(.TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .opcode_i(opcode), .alu_zero_i(alu_zero),
    .mem_ready_i(mem_ready), .mem_req_o(mem_req), .mem_we_o(mem_we),
    .addr_sel_o(addr_sel), .ir_we_o(ir_we), .pc_we_o(pc_we), .pc_src_o(pc_src),
    .alu_src_o(alu_src), .alu_op_o(alu_op), .reg_we_o(reg_we),
    .mem_to_reg_o(mem_to_reg), .retire_o(retire), .retired_cnt_o(retired_cnt),
    .trap_o(trap), .bus_err_o(bus_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         lat;
    logic [9:0] vec;   // {pc_we,pc_src,reg_we,mem_to_reg,mem_req,mem_we,addr_sel,alu_op,alu_src}
    logic [9:0] mask;
    logic [CNT_W-1:0] cnt;
  } exp_t;

  exp_t sbq[$];
  int checks = 0, errors = 0;
  int n_model = 0;
  logic [6:0] opc [5] = '{7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011, 7'b1100011};

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, req, $time);
    end
  endtask

  function automatic logic [11:0] all_outs();
    return {mem_req, mem_we, addr_sel, ir_we, pc_we, pc_src, alu_src, alu_op,
            reg_we, mem_to_reg, retire};
  endfunction

  // Expected retire-cycle behaviour derived from the instruction class rules.
  function automatic exp_t model(input int cls, input int fw, input int mw, input logic z);
    exp_t e;
    e.cnt  = CNT_W'(n_model);
    e.vec  = '0;
    e.mask = 10'h3FF;
    case (cls)
      BRANCH: begin e.lat = fw + 3;      e.vec = {z, z, 5'b0, 2'b01, 1'b0}; end
      STORE:  begin e.lat = fw + mw + 4; e.vec = {4'b0, 3'b111, 2'b00, 1'b1}; end
      LOAD:   begin e.lat = fw + mw + 5; e.vec = {2'b0, 2'b11, 6'b0}; e.mask = 10'h3F8; end
      default: begin e.lat = fw + 4;     e.vec = {2'b0, 2'b10, 6'b0}; e.mask = 10'h3F8; end
    endcase
    return e;
  endfunction

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic run_instr(input int cls, input int fw, input int mw, input logic z);
    sbq.push_back(model(cls, fw, mw, z));
    n_model++;
    opcode = opc[cls]; alu_zero = 1'($urandom); mem_ready = 1'b0;
    repeat (fw) tick();
    mem_ready = 1'b1; tick();              // DECODE next
    mem_ready = 1'b0; tick();              // EXEC next
    opcode = 7'($urandom); alu_zero = z; tick();
    if (cls == BRANCH) return;
    if (cls == R || cls == I) begin tick(); return; end
    repeat (mw) tick();                    // MEM wait cycles
    mem_ready = 1'b1; tick();
    mem_ready = 1'b0;
    if (cls == LOAD) tick();
  endtask

  task automatic do_reset();
    rst = 1'b1; mem_ready = 1'b0;
    @(negedge clk);
    chk("rst_outputs", {20'd0, all_outs()}, 32'd0);
    chk("rst_cnt", {28'd0, retired_cnt}, 32'd0);
    tick();
    rst = 1'b0;
    n_model = 0;
    sbq.delete();
  endtask

  // Monitor: pops the scoreboard on every retire pulse.
  int since = 0;
  always @(negedge clk) begin
    if (rst) begin
      since = 0;
    end else begin
      if (ir_we)
        chk("fetch_enables", {27'd0, pc_we, pc_src, mem_req, addr_sel, mem_we}, 32'b10100);
      if (retire) begin
        if (sbq.size() == 0) begin
          chk("unexpected_retire", 32'd1, 32'd0);
        end else begin
          exp_t e;
          logic [9:0] v;
          e = sbq.pop_front();
          v = {pc_we, pc_src, reg_we, mem_to_reg, mem_req, mem_we, addr_sel, alu_op, alu_src};
          chk("retire_latency", since + 1, e.lat);
          chk("retire_enables", {22'd0, v & e.mask}, {22'd0, e.vec & e.mask});
          chk("retired_cnt", {28'd0, retired_cnt}, {28'd0, e.cnt});
        end
        since = 0;
      end else begin
        since++;
      end
    end
  end

  initial begin
    do_reset();
    // ADD with no waits, then boundary waits one short of the timeout.
    run_instr(R, 0, 0, 1'b0);
    run_instr(R, TIMEOUT - 1, 0, 1'b0);
    run_instr(LOAD, 0, TIMEOUT - 1, 1'b0);
    run_instr(BRANCH, 0, 0, 1'b1);
    run_instr(BRANCH, 0, 0, 1'b0);
    for (int k = 0; k < 37; k++)
      run_instr(int'($urandom_range(0, 4)), int'($urandom_range(0, TIMEOUT - 1)),
                int'($urandom_range(0, TIMEOUT - 1)), 1'($urandom));
    @(negedge clk);
    chk("sb_drained", sbq.size(), 0);
    chk("no_trap_normal", {31'd0, trap}, 32'd0);

    // Reset in the middle of a store's memory phase.
    opcode = opc[STORE]; mem_ready = 1'b1; tick();
    mem_ready = 1'b0; tick(); tick(); tick();
    @(negedge clk);
    chk("sw_mem_phase", {29'd0, mem_req, mem_we, addr_sel}, 32'b111);
    do_reset();
    @(negedge clk);
    chk("post_rst_fetch", {28'd0, mem_req, addr_sel, mem_we, trap}, 32'b1000);
    chk("post_rst_cnt", {28'd0, retired_cnt}, 32'd0);

    // Illegal opcode traps after DECODE and stays inert.
    opcode = 7'b1111111; mem_ready = 1'b1; tick();
    mem_ready = 1'b0; tick();
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("ill_trap", {30'd0, trap, bus_err}, 32'b10);
      chk("ill_enables", {20'd0, all_outs()}, 32'd0);
      mem_ready = 1'($urandom); opcode = opc[k % 5]; tick();
    end

    // Fetch never acknowledged: bus timeout after TIMEOUT wait cycles.
    do_reset();
    for (int k = 0; k < TIMEOUT; k++) begin
      @(negedge clk);
      chk("tmo_waiting", {30'd0, mem_req, trap}, 32'b10);
      tick();
    end
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("tmo_trapped", {29'd0, mem_req, trap, bus_err}, 32'b011);
      tick();
    end
    do_reset();
    @(negedge clk);
    chk("tmo_rst_clear", {29'd0, trap, bus_err, mem_req}, 32'b001);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

endmodule

`default_nettype wire
